// File: rtl/spart_pkg.sv
// spart_pkg: shared bus addresses, status layout, FSM state types and divisor defaults for the SPART.
package spart_pkg;
  localparam logic [1:0] ADDR_BUF = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL = 2'b10;
  localparam logic [1:0] ADDR_DBH = 2'b11;
  localparam int ST_TBR = 0;
  localparam int ST_RDA = 1;
  localparam int ST_FERR = 2;
  localparam int ST_OVR = 3;
  localparam logic [15:0] RST_DIVISOR = 16'h1458;
  localparam logic [15:0] MIN_DIVISOR = 16'd16;
  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return d < MIN_DIVISOR ? MIN_DIVISOR : d;
  endfunction
endpackage

// File: rtl/spart_rx.sv
// spart_rx: synchronizes rxd and deserializes 8N1 frames, sampling mid-bit; done/ferr are valid while done is high.
module spart_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic [15:0] div,
  output logic [7:0]  data,
  output logic        done,
  output logic        ferr
);
  import spart_pkg::*;
  logic [2:0] sync_q, sync_d;
  rx_state_t st_q, st_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sr_q, sr_d;
  logic s;
  assign s = sync_q[1];
  assign data = sr_q;
  assign done = st_q == RX_STOP && cnt_q == '0;
  assign ferr = ~s;
  always_comb begin
    sync_d = {sync_q[1:0], rxd};
    st_d = st_q;
    cnt_d = cnt_q - 16'd1;
    bit_d = bit_q;
    sr_d = sr_q;
    case (st_q)
      RX_IDLE: begin
        cnt_d = (div >> 1) - 16'd1;
        if (sync_q[2] & ~s) st_d = RX_START;
      end
      RX_START: if (cnt_q == '0) begin
        st_d = s ? RX_IDLE : RX_DATA;
        cnt_d = div - 16'd1;
        bit_d = '0;
      end
      RX_DATA: if (cnt_q == '0) begin
        sr_d = {s, sr_q[7:1]};
        bit_d = bit_q + 3'd1;
        cnt_d = div - 16'd1;
        if (bit_q == 3'd7) st_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == '0) st_d = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 3'b111;
      st_q <= RX_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sr_q <= '0;
    end else begin
      sync_q <= sync_d;
      st_q <= st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sr_q <= sr_d;
    end
  end
endmodule

// File: rtl/spart.sv
// spart: bus-side SPART with register decode, programmable divisor, 8N1 transmitter and rda/tbr/error flags.
module spart (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);
  import spart_pkg::*;
  logic [15:0] div_q, div_d, dval;
  tx_state_t tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [3:0] tx_bit_q, tx_bit_d;
  logic [8:0] tx_sr_q, tx_sr_d;
  logic txd_q, txd_d, tbr_q, tbr_d;
  logic [7:0] buf_q, buf_d, stat, rd_data, rx_data;
  logic rda_q, rda_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic rx_done, rx_ferr, wr, rd, rd_buf, rd_stat;
  assign dval = eff_div(div_q);
  assign wr = iocs & ~iorw;
  assign rd = iocs & iorw;
  assign rd_buf = rd && ioaddr == ADDR_BUF;
  assign rd_stat = rd && ioaddr == ADDR_STAT;
  assign databus = rd ? rd_data : 8'bz;
  assign rda = rda_q;
  assign tbr = tbr_q;
  assign txd = txd_q;
  spart_rx u_rx (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .div(dval),
    .data(rx_data),
    .done(rx_done),
    .ferr(rx_ferr)
  );
  always_comb begin
    stat = '0;
    stat[ST_TBR] = tbr_q;
    stat[ST_RDA] = rda_q;
    stat[ST_FERR] = ferr_q;
    stat[ST_OVR] = ovr_q;
    rd_data = ioaddr == ADDR_BUF ? buf_q : ioaddr == ADDR_STAT ? stat : ioaddr == ADDR_DBL ? div_q[7:0] : div_q[15:8];
    div_d = {wr && ioaddr == ADDR_DBH ? databus : div_q[15:8], wr && ioaddr == ADDR_DBL ? databus : div_q[7:0]};
    tx_st_d = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sr_d = tx_sr_q;
    txd_d = txd_q;
    tbr_d = tbr_q;
    if (tx_st_q == TX_IDLE) begin
      if (wr && ioaddr == ADDR_BUF && tbr_q) begin
        tx_st_d = TX_SHIFT;
        tx_cnt_d = dval - 16'd1;
        tx_bit_d = '0;
        tx_sr_d = {1'b1, databus};
        txd_d = 1'b0;
        tbr_d = 1'b0;
      end
    end else if (tx_cnt_q != '0) begin
      tx_cnt_d = tx_cnt_q - 16'd1;
    end else if (tx_bit_q == 4'd9) begin
      tx_st_d = TX_IDLE;
      txd_d = 1'b1;
      tbr_d = 1'b1;
    end else begin
      tx_bit_d = tx_bit_q + 4'd1;
      tx_cnt_d = dval - 16'd1;
      txd_d = tx_sr_q[0];
      tx_sr_d = {1'b1, tx_sr_q[8:1]};
    end
    buf_d = rx_done ? rx_data : buf_q;
    rda_d = rx_done | (rda_q & ~rd_buf);
    ferr_d = rx_done ? rx_ferr : ferr_q & ~rd_stat;
    ovr_d = (rx_done & rda_q & ~rd_buf) | (ovr_q & ~rd_stat);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= RST_DIVISOR;
      tx_st_q <= TX_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sr_q <= '1;
      txd_q <= 1'b1;
      tbr_q <= 1'b1;
      buf_q <= '0;
      rda_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      div_q <= div_d;
      tx_st_q <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sr_q <= tx_sr_d;
      txd_q <= txd_d;
      tbr_q <= tbr_d;
      buf_q <= buf_d;
      rda_q <= rda_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
    end
  end
endmodule

// File: tb/tb_spart.sv
// tb_spart: directed bus and serial vectors against hand-computed expectations for spart.
module tb_spart;
  logic clk = 0, rst = 0, iocs = 0, iorw = 0, rxd = 1, drv_en = 0;
  logic [1:0] ioaddr = 0;
  logic [7:0] drv = 0;
  wire [7:0] databus;
  logic rda, tbr, txd;
  int cyc = 0, n_chk = 0, n_fail = 0;
  assign databus = drv_en ? drv : 8'bz;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  spart dut (
    .clk(clk),
    .rst(rst),
    .iocs(iocs),
    .iorw(iorw),
    .ioaddr(ioaddr),
    .databus(databus),
    .rda(rda),
    .tbr(tbr),
    .txd(txd),
    .rxd(rxd)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask
  task automatic bus_wr(input logic [1:0] a, input logic [7:0] v);
    @(negedge clk);
    iocs = 1; iorw = 0; ioaddr = a; drv = v; drv_en = 1;
    @(negedge clk);
    iocs = 0; drv_en = 0;
  endtask
  task automatic bus_rd(input logic [1:0] a, output logic [7:0] v);
    @(negedge clk);
    iocs = 1; iorw = 1; ioaddr = a;
    #1 v = databus;
    @(negedge clk);
    iocs = 0; iorw = 0;
  endtask
  task automatic rx_frame(input logic [7:0] data, input logic stop);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (16) @(posedge clk);
      #1;
    end
    rxd = 1;
  endtask
  initial begin
    logic [7:0] d;
    logic [9:0] frame;
    int t0, lat;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("rst_tbr", tbr, 1);
    check("rst_rda", rda, 0);
    check("rst_txd", txd, 1);
    bus_rd(2'b10, d); check("rst_dbl", d, 8'h58);
    bus_rd(2'b11, d); check("rst_dbh", d, 8'h14);
    iocs = 0; iorw = 1; ioaddr = 2'b10; drv = 8'h00; drv_en = 1;
    #1 check("bus_released", databus, 8'h00);
    drv_en = 0; iorw = 0;
    bus_wr(2'b10, 8'h10);
    bus_wr(2'b11, 8'h00);
    bus_rd(2'b10, d); check("dbl_wr", d, 8'h10);
    bus_rd(2'b11, d); check("dbh_wr", d, 8'h00);
    bus_wr(2'b00, 8'h55);
    t0 = cyc;
    check("tx_tbr_low", tbr, 0);
    check("tx_start", txd, 0);
    frame = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 10; k++) begin
      wait_until(t0 + 16 * k + 8);
      check($sformatf("tx_bit%0d", k), txd, frame[k]);
      if (k == 0) bus_wr(2'b00, 8'hA3);
    end
    wait_until(t0 + 159); check("tbr_before_end", tbr, 0);
    wait_until(t0 + 160); check("tbr_at_end", tbr, 1);
    check("txd_at_end", txd, 1);
    wait_until(t0 + 200); check("no_second_frame", txd, 1);
    check("tbr_idle", tbr, 1);
    lat = 0;
    fork
      rx_frame(8'hC4, 1'b1);
      begin
        @(posedge clk); #1;
        t0 = cyc;
        while (!rda && cyc < t0 + 400) @(negedge clk);
        lat = cyc - t0;
      end
    join
    check("rx_lat_150_160", lat >= 150 && lat <= 160, 1);
    check("rx_rda_set", rda, 1);
    bus_rd(2'b00, d); check("rx_buf_c4", d, 8'hC4);
    check("rda_cleared", rda, 0);
    bus_rd(2'b01, d); check("stat_after_rx", d, 8'h01);
    @(negedge clk); rxd = 0;
    @(negedge clk); rxd = 1;
    wait_until(cyc + 100);
    check("glitch_no_rda", rda, 0);
    bus_rd(2'b01, d); check("glitch_stat", d, 8'h01);
    rx_frame(8'h5A, 1'b0);
    repeat (2) @(negedge clk);
    check("ferr_rda", rda, 1);
    bus_rd(2'b01, d); check("ferr_stat", d, 8'h07);
    bus_rd(2'b01, d); check("ferr_cleared", d, 8'h03);
    bus_rd(2'b00, d); check("ferr_buf", d, 8'h5A);
    rx_frame(8'h11, 1'b1);
    repeat (4) @(negedge clk);
    rx_frame(8'h22, 1'b1);
    repeat (2) @(negedge clk);
    bus_rd(2'b01, d); check("ovr_stat", d, 8'h0B);
    bus_rd(2'b00, d); check("ovr_buf", d, 8'h22);
    bus_rd(2'b01, d); check("ovr_cleared", d, 8'h01);
    bus_wr(2'b00, 8'h00);
    @(negedge clk); rxd = 0;
    repeat (40) @(negedge clk);
    check("pre_rst_txd", txd, 0);
    check("pre_rst_tbr", tbr, 0);
    #2 rst = 0;
    #1 check("async_rst_txd", txd, 1);
    check("async_rst_tbr", tbr, 1);
    check("async_rst_rda", rda, 0);
    rxd = 1;
    @(negedge clk); rst = 1;
    repeat (200) @(negedge clk);
    check("post_rst_rda", rda, 0);
    check("post_rst_txd", txd, 1);
    bus_rd(2'b10, d); check("post_rst_dbl", d, 8'h58);
    bus_rd(2'b11, d); check("post_rst_dbh", d, 8'h14);
    bus_rd(2'b01, d); check("post_rst_stat", d, 8'h01);
    bus_rd(2'b00, d); check("post_rst_buf", d, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spart.md
Name: spart

Overview:
- Bus-side responder for the processor/driver SPART interface: a special-purpose asynchronous receiver/transmitter.
- Decodes iocs/iorw/ioaddr transactions on the shared 8-bit tri-state databus.
- Serializes transmit bytes on txd and deserializes rxd into a receive buffer, using a programmable 16-bit divisor that counts clocks per bit.
- Reports rda/tbr handshake flags back to the driver and sits between the driver and the board UART pins.

Parameters:
- RST_DIVISOR, 16'h1458, divisor loaded at reset (9600 baud at 50 MHz).
- MIN_DIVISOR, 16, smallest effective divisor; smaller programmed values are clamped to this.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- iocs  in  1  chip select
- iorw  in  1  1 = read (SPART->driver), 0 = write (driver->SPART)
- ioaddr  in  2  00 TX/RX buffer, 01 status, 10 DB low, 11 DB high
- databus  inout  8  shared tri-state bus
- rda  out  1  receive data available
- tbr  out  1  transmit buffer ready
- txd  out  1  serial out, idle high
- rxd  in  1  serial in, asynchronous

Behaviour:
- Clocking and reset: one clock; reset is asynchronous, active-low on rst.
- Reset values: txd=1, tbr=1, rda=0, rx buffer=8'h00, status error bits=0, divisor=RST_DIVISOR. databus is Z.
- Effective divisor D = max(divisor, MIN_DIVISOR).
- Bus drive: databus is driven only when iocs & iorw; otherwise it is Z. Read data is combinational from ioaddr:
  - 00 = rx buffer
  - 01 = status {4'b0, overrun, ferr, rda, tbr}
  - 10 = divisor[7:0]
  - 11 = divisor[15:8]
- Writes: sampled on each clk edge where iocs & !iorw.
  - 10 loads divisor[7:0]; 11 loads divisor[15:8]. Each takes effect on the next bit-period reload, never mid-bit.
  - 00 loads the TX byte only if tbr=1; if tbr=0 the write is ignored.
  - 01 is ignored.
- Read side effects: any edge with iocs & iorw & ioaddr==00 clears rda; the buffer contents are held. Any edge with iocs & iorw & ioaddr==01 clears ferr and overrun. Repeated reads are harmless.
- TX FSM (TX_IDLE, TX_SHIFT):
  - An accepted write at edge N sets tbr=0 at N and txd=0 (start bit) at N.
  - Frame is start, 8 data bits LSB first, 1 stop bit; each bit lasts D cycles.
  - tbr returns to 1 at the end of the stop bit, after 10*D cycles. Back-to-back write is then allowed the same cycle.
- RX: rxd is passed through a 2-flop synchronizer. RX FSM states:
  - RX_IDLE: a synchronized falling edge enters RX_START.
  - RX_START: wait D>>1 cycles. If rxd is still 0, go to RX_DATA; else return to RX_IDLE (glitch rejected, no flags).
  - RX_DATA: sample every D cycles, 8 bits, LSB first.
  - RX_STOP: sample after D cycles. Write the rx buffer, set rda=1, set ferr = ~stop_sample, return to RX_IDLE.
  - Latency: rda rises about 9.5*D + 2 cycles after the start-bit falling edge.
- Overrun: a frame completing while rda=1 overwrites the buffer and sets overrun (sticky). If a completion and an rda-clearing read land on the same edge, the completion wins: rda=1 and overrun is not set.
- Divisor write during an active frame: the current bit finishes on the old D.
- Reset mid-frame: both FSMs abort to idle immediately; txd=1.

Decomposition:
- spart_pkg holds:
  - address constants ADDR_BUF, ADDR_STAT, ADDR_DBL, ADDR_DBH
  - status bit indices
  - tx_state_t {TX_IDLE, TX_SHIFT}
  - rx_state_t {RX_IDLE, RX_START, RX_DATA, RX_STOP}
  - RST_DIVISOR default
- One sub-module, spart_rx, contains the synchronizer, RX FSM, bit counter and shift register. It outputs a byte plus done/ferr pulses. The top level holds the bus decode, divisor, TX path, status and rda/overrun flags.

Test Plan:
- Reset, then read addr 10/11 -> databus 8'h58, 8'h14. With iocs=0, databus=Z; tbr=1, rda=0, txd=1.
- Write DB low 8'h10, DB high 8'h00 (D=16), then write 8'h55 at addr 00 -> tbr=0 next edge. txd = 0,1,0,1,0,1,0,1,0,1, each bit 16 cycles. tbr=1 exactly 160 cycles after the write.
- D=16, write 8'hA3 while tbr=0 -> ignored. txd still carries the first byte; no second frame follows.
- D=16, drive rxd frame 8'hC4 with valid stop -> rda=1 about 154 cycles after the start edge. Read addr 00 = 8'hC4 and rda clears. Status = 8'h01.
- D=16, 1-cycle-wide rxd low pulse -> no rda. Then a frame with stop=0 -> rda=1, status bit2=1. A status read clears bit2.
- D=16, two frames 8'h11 then 8'h22 without reading -> buffer 8'h22, status = 8'h0B. Assert rst mid third frame -> txd=1, rda=0, divisor=16'h1458.
